// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore-style control sequencer for a multi-cycle MIPS
// datapath with one shared ALU and one unified memory. Steps FETCH -> DECODE ->
// execute states, drives every mux select / enable, stalls on mem_ready,
// counts retired instructions and flags illegal opcodes in DECODE.
// Optional feature macro: MCU_JUMP_EN (adds the J instruction / JUMP state).
module multicycle_control_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8
`ifdef MCU_JUMP_EN
    , S_JUMP = 4'd9
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MCU_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic             w_legal;
  logic [CNT_W-1:0] r_retired;

  // Opcode legality as seen by DECODE
  always_comb begin
    w_legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: w_legal = 1'b1;
`ifdef MCU_JUMP_EN
      OP_J:                           w_legal = 1'b1;
`endif
      default:                        w_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Retired-instruction counter, wraps modulo 2**CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNT_W'(1);
  end

  // Next-state selection and instruction-completion strobe
  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
`ifdef MCU_JUMP_EN
          OP_J:         w_next = S_JUMP;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      w_next = S_MEMRD;
        else if (op == OP_SW) w_next = S_MEMWR;
        else                  w_next = S_FETCH;
      end
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  begin w_next = S_FETCH; w_retire = 1'b1; end
      S_MEMWR:  begin
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
        w_retire = mem_ready;
      end
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  begin w_next = S_FETCH; w_retire = 1'b1; end
      S_BRANCH: begin w_next = S_FETCH; w_retire = 1'b1; end
`ifdef MCU_JUMP_EN
      S_JUMP:   begin w_next = S_FETCH; w_retire = 1'b1; end
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  // Control decode from current state. The FETCH-stage ir_write/pc_write are
  // qualified by mem_ready so IR/PC load exactly once, in the completing cycle;
  // every other output depends on state alone.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
      end
`ifdef MCU_JUMP_EN
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
`endif
      // Unreachable encodings: FETCH mux settings, all enables off
      default: alu_src_b = 2'b01;
    endcase
  end

  assign state      = r_state;
  assign retired    = r_retired;
  assign illegal_op = (r_state == S_DECODE) && !w_legal;

endmodule
